// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// valid/ready requesters. The winner keeps the port for up to MAX_BURST
// accepted beats. The grant then rotates, and one idle cycle is spent on
// each arbitration.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BITS      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [BITS-1:0]           fifo_wr_data,
  input  logic                      fifo_wr_full,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                      grant_active
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   next_ptr;
  logic            g_valid;
  logic            in_burst;

  assign in_burst = (state_q == BURST);
  assign g_valid  = req_valid[grant_q];
  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

  // Round-robin search: first valid requester starting at rr_q, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats and decide when to release in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!g_valid) begin
          // Owner went quiet (even during a stall): give up the port.
          state_d = IDLE;
          rr_d    = next_ptr;
        end else if (!fifo_wr_full) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any burst and restarts the search at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port mux: only the owner sees ready, and nothing moves while reset is high.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && in_burst && !fifo_wr_full && (grant_q == GW'(i));
    end
    fifo_wr_en   = !rst && in_burst && g_valid && !fifo_wr_full;
    fifo_wr_data = req_data[int'(grant_q)*BITS +: BITS];
    grant_active = !rst && in_burst;
    grant_id     = grant_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (NUM_REQ=4, BITS=32, MAX_BURST=4).
// Per-cycle vector table of inputs and expected control outputs, plus a
// queue of expected FIFO writes that is drained whenever the DUT writes.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int BW = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           fifo_wr_en;
  logic [BW-1:0]  fifo_wr_data;
  logic           fifo_wr_full;
  logic [1:0]     grant_id;
  logic           grant_active;

  fifo_wr_arbiter #(.NUM_REQ(NR), .BITS(BW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_full (fifo_wr_full),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic [3:0] ready;
    logic       wen;
    logic [1:0] gid;
    logic       act;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          pushed   = 0;
  int          popped   = 0;
  int          seq[NR];

  task automatic add(input logic r, input logic [3:0] v, input logic f,
                     input logic [3:0] rdy, input logic w, input logic [1:0] g,
                     input logic a);
    vec_t t;
    t.rst = r; t.valid = v; t.full = f;
    t.ready = rdy; t.wen = w; t.gid = g; t.act = a;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] actv, input logic [31:0] expv);
    checks++;
    if (actv !== expv) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, actv, expv);
    end
  endtask

  // Scoreboard: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got=%0h want=none", fifo_wr_data);
      end else begin
        chk("wr_data", popped, fifo_wr_data, exp_q.pop_front());
        popped++;
      end
    end
  end

  initial begin
    // Reset row, then 20 idle cycles with nothing requested.
    add(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 20; i++) add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

    // Req 0 alone for 6 beats: 4-beat burst, idle, 2 more beats, valid drops.
    add(0, 4'b0001, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
    add(0, 4'b0001, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b0001, 0, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

    // Reset to put the pointer back at 0, then all four valid: order 0,1,2,3,0.
    add(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0010, 1, 2'd1, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 2'd1, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0100, 1, 2'd2, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 2'd2, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b1000, 1, 2'd3, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 2'd3, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

    // Req 1: 2 beats, full for 3 cycles, then 2 more beats.
    add(0, 4'b0010, 0, 4'b0000, 0, 2'd0, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0010, 1, 4'b0000, 0, 2'd1, 1);
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd1, 0);

    // Req 2: full in its first burst cycle, 2 beats, then drops while req 3 waits.
    add(0, 4'b0100, 0, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b0100, 1, 4'b0000, 0, 2'd2, 1);
    for (int i = 0; i < 2; i++) add(0, 4'b1100, 0, 4'b0100, 1, 2'd2, 1);
    add(0, 4'b1000, 0, 4'b0100, 0, 2'd2, 1);
    add(0, 4'b1000, 0, 4'b0000, 0, 2'd2, 0);
    add(0, 4'b1000, 0, 4'b1000, 1, 2'd3, 1);
    // Req 3 drops valid during a stall: still releases. The pointer wraps to 0, so req 1 wins.
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
    add(0, 4'b0010, 0, 4'b0000, 0, 2'd3, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 1, 2'd1, 1);

    // Reset mid-burst; reqs 1 and 3 valid, so the search from 0 picks 1.
    add(1, 4'b1010, 0, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b1010, 0, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1010, 0, 4'b0010, 1, 2'd1, 1);
    add(0, 4'b1000, 0, 4'b0010, 0, 2'd1, 1);
    add(0, 4'b1000, 0, 4'b0000, 0, 2'd1, 0);

    for (int i = 0; i < NR; i++) seq[i] = 0;
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    fifo_wr_full = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < vecs.size(); r++) begin
      #1;
      rst          = vecs[r].rst;
      req_valid    = vecs[r].valid;
      fifo_wr_full = vecs[r].full;
      for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = {8'(i), 24'(seq[i])};
      if (vecs[r].wen) begin
        exp_q.push_back({8'(vecs[r].gid), 24'(seq[vecs[r].gid])});
        pushed++;
      end
      @(negedge clk);
      chk("req_ready",    r, 32'(req_ready),    32'(vecs[r].ready));
      chk("fifo_wr_en",   r, 32'(fifo_wr_en),   32'(vecs[r].wen));
      chk("grant_id",     r, 32'(grant_id),     32'(vecs[r].gid));
      chk("grant_active", r, 32'(grant_active), 32'(vecs[r].act));
      if (vecs[r].wen) seq[vecs[r].gid]++;
      @(posedge clk);
    end

    #2;
    chk("writes_seen", 0, 32'(popped), 32'(pushed));
    chk("sb_left",     0, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
